// File: rtl/collision_pkg.sv
// Shared types and pair-indexing helpers for the collision manager.
// Pairs (i,j), i<j, are numbered row by row: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
package collision_pkg;

  typedef enum logic {
    StWaitSof,
    StRun
  } state_e;

  function automatic int unsigned num_pairs(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/collision_pair_tracker.sv
// One pair's overlap run counter, per-frame hit flag, hit pulse and saturating frame counter.
module collision_pair_tracker #(
  parameter int unsigned MIN_OVERLAP = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en_i,
  input  logic             sof_i,
  input  logic             overlap_i,
  input  logic             cnt_clr_i,
  output logic             hit_o,
  output logic             flag_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned RunW = $clog2(MIN_OVERLAP + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MIN_OVERLAP);

  logic [RunW-1:0]  run_q, run_d;
  logic             flag_q, flag_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    run_d  = run_q;
    flag_d = flag_q;
    hit_d  = 1'b0;
    cnt_d  = cnt_q;
    if (en_i) begin
      // An overlap seen together with start-of-frame opens a fresh run in the new frame.
      if (!overlap_i) begin
        run_d = '0;
      end else if (sof_i) begin
        run_d = RunW'(1);
      end else if (run_q != RunMax) begin
        run_d = run_q + 1'b1;
      end
      hit_d  = (run_d == RunMax) && (sof_i || !flag_q);
      flag_d = (flag_q && !sof_i) || hit_d;
    end
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (hit_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      run_q  <= '0;
      flag_q <= 1'b0;
      hit_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      run_q  <= run_d;
      flag_q <= flag_d;
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hit_o  = hit_q;
  assign flag_o = flag_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/collision_manager.sv
// Pairwise collision detection between drawing-request channels with per-frame hit summary.
module collision_manager
  import collision_pkg::*;
#(
  parameter int unsigned NUM_OBJ     = 5,
  parameter int unsigned MIN_OVERLAP = 1,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned NUM_PAIRS  = num_pairs(NUM_OBJ)
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [NUM_OBJ-1:0]         draw_req,
  input  logic [NUM_PAIRS-1:0]       pair_en,
  input  logic                       cnt_clr,
  output logic [NUM_PAIRS-1:0]       hit_pulse,
  output logic                       any_hit_pulse,
  output logic [NUM_PAIRS-1:0]       frame_hits,
  output logic                       summary_valid,
  output logic [NUM_PAIRS*CNT_W-1:0] pair_cnt
);

  state_e                 state_q, state_d;
  logic [NUM_OBJ-1:0]     req_q;
  logic [NUM_PAIRS-1:0]   en_q;
  logic                   sof_q;
  logic [NUM_PAIRS-1:0]   frame_hits_q, frame_hits_d;
  logic                   summary_q, summary_d;
  logic [NUM_PAIRS-1:0]   overlap;
  logic [NUM_PAIRS-1:0]   flags;
  logic                   run;

  always_comb begin
    state_d      = state_q;
    frame_hits_d = frame_hits_q;
    summary_d    = 1'b0;
    run          = 1'b0;
    unique case (state_q)
      StWaitSof: begin
        if (sof_q) state_d = StRun;
      end
      StRun: begin
        run = 1'b1;
        // Flags still hold the finished frame here; trackers clear them on this edge.
        if (sof_q) begin
          frame_hits_d = flags;
          summary_d    = 1'b1;
        end
      end
      default: state_d = StWaitSof;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StWaitSof;
      req_q        <= '0;
      en_q         <= '0;
      sof_q        <= 1'b0;
      frame_hits_q <= '0;
      summary_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= draw_req;
      en_q         <= pair_en;
      sof_q        <= startOfFrame;
      frame_hits_q <= frame_hits_d;
      summary_q    <= summary_d;
    end
  end

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj_i
    for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_obj_j
      localparam int unsigned P = pair_idx(i, j, NUM_OBJ);

      assign overlap[P] = req_q[i] & req_q[j] & en_q[P];

      collision_pair_tracker #(
        .MIN_OVERLAP (MIN_OVERLAP),
        .CNT_W       (CNT_W)
      ) u_tracker (
        .clk       (clk),
        .resetN    (resetN),
        .en_i      (run),
        .sof_i     (sof_q),
        .overlap_i (overlap[P]),
        .cnt_clr_i (cnt_clr),
        .hit_o     (hit_pulse[P]),
        .flag_o    (flags[P]),
        .cnt_o     (pair_cnt[P*CNT_W +: CNT_W])
      );
    end
  end

  assign any_hit_pulse = |hit_pulse;
  assign frame_hits    = frame_hits_q;
  assign summary_valid = summary_q;

endmodule

// File: tb/tb_collision_manager.sv
// Directed bench for collision_manager: NUM_OBJ=5, MIN_OVERLAP=3, CNT_W=8.
module tb_collision_manager;

  localparam int NO = 5;
  localparam int NP = 10;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic [NO-1:0]     draw_req = '0;
  logic [NP-1:0]     pair_en = '1;
  logic              cnt_clr = 1'b0;
  logic [NP-1:0]     hit_pulse;
  logic              any_hit_pulse;
  logic [NP-1:0]     frame_hits;
  logic              summary_valid;
  logic [NP*CW-1:0]  pair_cnt;

  collision_manager #(
    .NUM_OBJ     (NO),
    .MIN_OVERLAP (3),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .draw_req      (draw_req),
    .pair_en       (pair_en),
    .cnt_clr       (cnt_clr),
    .hit_pulse     (hit_pulse),
    .any_hit_pulse (any_hit_pulse),
    .frame_hits    (frame_hits),
    .summary_valid (summary_valid),
    .pair_cnt      (pair_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int hit_tot[NP];
  int sv_tot = 0;
  int exp_cnt[NP];

  always @(negedge clk) begin
    if (resetN) begin
      for (int p = 0; p < NP; p++) if (hit_pulse[p]) hit_tot[p]++;
      if (summary_valid) sv_tot++;
    end
  end

  typedef struct {
    logic [NO-1:0] req;
    logic [NP-1:0] en;
    int            n;
    logic [NP-1:0] mask;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [NP*CW-1:0] act,
                     input logic [NP*CW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_sof();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(2);
  endtask

  function automatic logic [NP*CW-1:0] exp_pc();
    logic [NP*CW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*CW +: CW] = CW'(exp_cnt[p]);
    return v;
  endfunction

  int base[NP];
  int sv_base;
  logic [NP-1:0] act_mask;
  int act_sum;

  task automatic snap();
    for (int p = 0; p < NP; p++) base[p] = hit_tot[p];
    sv_base = sv_tot;
  endtask

  task automatic deltas();
    act_mask = '0;
    act_sum  = 0;
    for (int p = 0; p < NP; p++) begin
      act_mask[p] = (hit_tot[p] != base[p]);
      act_sum += hit_tot[p] - base[p];
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    vecs[0] = '{req: 5'b00011, en: 10'h3FF, n: 3, mask: 10'h001};
    vecs[1] = '{req: 5'b00011, en: 10'h3FF, n: 2, mask: 10'h000};
    vecs[2] = '{req: 5'b10110, en: 10'h3FF, n: 3, mask: 10'h150};
    vecs[3] = '{req: 5'b10110, en: 10'h3BF, n: 3, mask: 10'h110};
    vecs[4] = '{req: 5'b11000, en: 10'h3FF, n: 5, mask: 10'h200};
    vecs[5] = '{req: 5'b11111, en: 10'h3FF, n: 3, mask: 10'h3FF};
    vecs[6] = '{req: 5'b00101, en: 10'h3FF, n: 4, mask: 10'h002};
    vecs[7] = '{req: 5'b11000, en: 10'h1FF, n: 6, mask: 10'h000};

    // Reset state and detection blocked before the first start-of-frame.
    tick(3);
    chk("reset_hit_pulse", 80'(hit_pulse), 80'h0);
    chk("reset_pair_cnt", pair_cnt, 80'h0);
    resetN = 1'b1;
    tick(1);
    snap();
    draw_req = 5'b00011;
    tick(10);
    draw_req = '0;
    tick(3);
    deltas();
    chk("pre_sof_no_hits", 80'(act_sum), 80'h0);
    chk("pre_sof_pair_cnt", pair_cnt, 80'h0);
    snap();
    do_sof();
    tick(2);
    chk("first_sof_no_summary", 80'(sv_tot - sv_base), 80'h0);

    // Table of single-frame overlap patterns.
    for (int v = 0; v < 8; v++) begin
      do_sof();
      snap();
      draw_req = vecs[v].req;
      pair_en  = vecs[v].en;
      tick(vecs[v].n);
      draw_req = '0;
      pair_en  = '1;
      tick(4);
      deltas();
      chk($sformatf("vec%0d_mask", v), 80'(act_mask), 80'(vecs[v].mask));
      chk($sformatf("vec%0d_pulses", v), 80'(act_sum), 80'($countones(vecs[v].mask)));
      for (int p = 0; p < NP; p++) if (vecs[v].mask[p]) exp_cnt[p]++;
      chk($sformatf("vec%0d_pair_cnt", v), pair_cnt, exp_pc());
    end

    // Three-clock latency from first sampled overlap to the pulse.
    do_sof();
    draw_req = 5'b00011;
    tick(3);
    draw_req = '0;
    chk("latency_before", 80'(hit_pulse), 80'h0);
    tick(1);
    chk("latency_hit", 80'(hit_pulse), 80'h001);
    chk("latency_any", 80'(any_hit_pulse), 80'h1);
    tick(1);
    chk("latency_single", 80'(hit_pulse), 80'h0);
    exp_cnt[0]++;

    // Two bursts in one frame give one pulse; next frame start reports it.
    do_sof();
    snap();
    for (int b = 0; b < 2; b++) begin
      draw_req = 5'b11000;
      tick(5);
      draw_req = '0;
      tick(3);
    end
    deltas();
    chk("burst_pulses", 80'(hit_tot[9] - base[9]), 80'h1);
    exp_cnt[9]++;
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(1);
    chk("summary_valid_hi", 80'(summary_valid), 80'h1);
    chk("frame_hits", 80'(frame_hits), 80'h200);
    tick(1);
    chk("summary_valid_lo", 80'(summary_valid), 80'h0);
    chk("burst_pair_cnt", pair_cnt, exp_pc());

    // Asynchronous reset in the middle of an overlap, then no detection until a new SOF.
    draw_req = 5'b00011;
    tick(2);
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_hit_pulse", 80'(hit_pulse), 80'h0);
    chk("arst_any_hit", 80'(any_hit_pulse), 80'h0);
    chk("arst_frame_hits", 80'(frame_hits), 80'h0);
    chk("arst_summary", 80'(summary_valid), 80'h0);
    chk("arst_pair_cnt", pair_cnt, 80'h0);
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    #3;
    resetN = 1'b1;
    tick(1);
    snap();
    tick(10);
    draw_req = '0;
    tick(2);
    deltas();
    chk("post_rst_no_hits", 80'(act_sum), 80'h0);
    do_sof();

    // Counter saturation and clear.
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("cnt_clr_initial", pair_cnt, 80'h0);
    for (int f = 0; f < 300; f++) begin
      do_sof();
      draw_req = 5'b00011;
      tick(3);
      draw_req = '0;
      tick(2);
    end
    exp_cnt[0] = 255;
    chk("pair_cnt_saturated", pair_cnt, exp_pc());
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("pair_cnt_cleared", pair_cnt, 80'h0);

    // Clear on the same edge as a hit wins.
    do_sof();
    draw_req = 5'b00011;
    tick(3);
    draw_req = '0;
    cnt_clr  = 1'b1;
    tick(1);
    cnt_clr  = 1'b0;
    chk("clr_vs_hit_pulse", 80'(hit_pulse), 80'h001);
    chk("clr_vs_hit_cnt", pair_cnt, 80'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/collision_manager.md
COLLISION_MANAGER -- requirements
Module: collision_manager

Interface
REQ-001 Parameter NUM_OBJ, default 5, number of drawing-request channels (2..8).
REQ-002 Parameter MIN_OVERLAP, default 1, consecutive overlapping clocks needed to declare a hit (1..255).
REQ-003 Parameter CNT_W, default 8, width of each per-pair frame counter.
REQ-004 Derived constant NUM_PAIRS = NUM_OBJ*(NUM_OBJ-1)/2; pair p(i,j), i<j, ordered (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-clock pulse at frame start.
REQ-008 draw_req  in  NUM_OBJ  per-object drawing request for the current pixel.
REQ-009 pair_en  in  NUM_PAIRS  per-pair detection enable.
REQ-010 cnt_clr  in  1  synchronous clear of all pair counters.
REQ-011 hit_pulse  out  NUM_PAIRS  one-clock pulse, at most once per pair per frame.
REQ-012 any_hit_pulse  out  1  OR of hit_pulse.
REQ-013 frame_hits  out  NUM_PAIRS  hits of the previous completed frame.
REQ-014 summary_valid  out  1  one-clock pulse when frame_hits updates.
REQ-015 pair_cnt  out  NUM_PAIRS*CNT_W  per-pair count of frames with a hit, pair p in bits [p*CNT_W +: CNT_W].

Function
REQ-016 The block SHALL register draw_req, pair_en and startOfFrame once; overlap(p) = both registered requests of pair p high and registered pair_en[p] high.
REQ-017 FSM states: WAIT_SOF (after reset, no detection), RUN; WAIT_SOF->RUN on registered startOfFrame; RUN has no exit except reset.
REQ-018 Per pair, a run counter SHALL increment while overlap(p) holds, clear when it drops, clear on registered startOfFrame, and saturate at MIN_OVERLAP.
REQ-019 hit_pulse[p] SHALL assert for one clock when the run counter reaches MIN_OVERLAP and the pair frame flag is clear; the frame flag then sets.
REQ-020 Latency: with MIN_OVERLAP=1, hit_pulse is high the second clock edge after draw_req overlap is sampled (2 clocks).
REQ-021 On registered startOfFrame in RUN: frame_hits <= frame flags (including any hit set that cycle before clear), summary_valid pulses, all frame flags clear.
REQ-022 An overlap present in the startOfFrame cycle SHALL count toward the new frame only.
REQ-023 pair_cnt[p] SHALL increment by one on each hit_pulse[p], saturating at 2^CNT_W-1.
REQ-024 cnt_clr SHALL zero all pair_cnt; cnt_clr coincident with a hit yields count 0.
REQ-025 Multiple pairs MAY pulse in the same clock; each is independent.
REQ-026 In WAIT_SOF no hit_pulse, summary_valid or counting SHALL occur.

Reset
REQ-027 resetN low SHALL force state WAIT_SOF and zero all registers and outputs (hit_pulse, any_hit_pulse, frame_hits, summary_valid, pair_cnt, run counters, flags) immediately.
REQ-028 Reset mid-frame SHALL discard partial frame state; detection resumes only after the next startOfFrame.

Structure
REQ-029 Package collision_pkg SHALL hold the FSM state typedef and the pair-index function p(i,j) / NUM_PAIRS computation.
REQ-030 One sub-module, collision_pair_tracker, SHALL implement one pair's run counter, frame flag, pulse and saturating counter; instantiated NUM_PAIRS times by generate.

Verification (NUM_OBJ=5, MIN_OVERLAP=3, CNT_W=8, pair_en all 1)
REQ-031 Reset, no startOfFrame, draw_req=5'b00011 for 10 clocks -> no hit_pulse, pair_cnt all 0.
REQ-032 After SOF, draw_req=5'b00011 for 3 clocks -> hit_pulse[0] single pulse; 2 clocks overlap only -> no pulse.
REQ-033 Two overlap bursts of 5 clocks on objects 3,4 in one frame -> exactly one hit_pulse[9]; next SOF -> frame_hits[9]=1, summary_valid pulse, pair_cnt[9]=1.
REQ-034 draw_req=5'b10110 for 3 clocks -> hit_pulse bits 4,6,8 (pairs (1,2),(1,4),(2,4)) together; pair_en[6]=0 -> bit 6 absent.
REQ-035 Hit on pair 0 in 300 frames -> pair_cnt[0] saturates at 255; cnt_clr -> 0.
REQ-036 resetN low mid-overlap -> all outputs 0 asynchronously; overlap resumed without SOF -> no pulse.
